// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART TX arbiter slice.
//   state_t : arbiter FSM encoding (ST_IDLE = 0, ST_LOCK = 1)
//   clog2() : index/counter width helper, never returns less than 1
package uart_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int width;
    width = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational rotating priority encoder.
//   req        : request vector, one bit per port
//   last_grant : most recently granted port; the search starts just above it
//   found      : at least one request is present
//   index      : first requesting port found, searching upward with wrap
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int IDX_W   = clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  int cand;

  // Walk from the farthest candidate back to the nearest so the nearest
  // requester above last_grant is the one that sticks.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = 0;
    for (int i = N_PORTS; i >= 1; i--) begin
      cand = (int'(last_grant) + i) % N_PORTS;
      if (req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        index = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin, packet-locked arbiter sharing one AXI4-Stream
// UART transmitter among N_PORTS byte-stream requesters. A grant is held
// from the first beat to tlast so messages never interleave; the output
// beat is registered so the UART's tready only reaches the requester side
// through the granted port's ready.
//
// Optional feature macro: UART_TX_ARB_TIMEOUT_EN adds a stall watchdog that
// releases a grant after TIMEOUT_CYCLES cycles without a valid beat.
//
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   s_axis_*       : N_PORTS packed requester streams (port i at slice i)
//   m_axis_*       : single stream towards the UART TX (tlast not forwarded)
//   grant_id       : locked port index, meaningful while busy
//   busy           : locked, or output register still holds a beat
//   timeout        : one-cycle pulse when the watchdog drops a grant
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no grant; arbitrate among valid requesters, accept nothing
// ST_LOCK | grant_id owns the output until its tlast (or a watchdog trip)
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_PORTS        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N_PORTS-1:0]            s_axis_tvalid,
  input  logic [N_PORTS-1:0]            s_axis_tlast,
  output logic [N_PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [clog2(N_PORTS)-1:0]     grant_id,
  output logic                          busy,
  output logic                          timeout
);

  localparam int IW = clog2(N_PORTS);

  if (N_PORTS < 2 || N_PORTS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_tx_arb: parameter out of range");
  end

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   last_nxt;
  logic [IW-1:0]   grant_nxt;
  logic            arb_found;
  logic [IW-1:0]   arb_index;
  logic            grant_ready;
  logic            accept;
  logic            accept_last;
  logic            timeout_hit;
  logic [DATA_WIDTH-1:0] beat_data;

  uart_rr_arbiter #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IW)
  ) u_arb (
    .req        (s_axis_tvalid),
    .last_grant (last_grant),
    .found      (arb_found),
    .index      (arb_index)
  );

  // Ready depends only on registered state and the UART's ready, never on
  // any requester's valid.
  assign grant_ready = (state == ST_LOCK) && (!m_axis_tvalid || m_axis_tready);
  assign accept      = grant_ready && s_axis_tvalid[grant_id];
  assign accept_last = accept && s_axis_tlast[grant_id];
  assign beat_data   = s_axis_tdata[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign busy        = (state == ST_LOCK) || m_axis_tvalid;

  always_comb begin
    s_axis_tready = '0;
    if (grant_ready) s_axis_tready[grant_id] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    last_nxt  = last_grant;
    case (state)
      ST_IDLE: begin
        if (arb_found) begin
          state_nxt = ST_LOCK;
          grant_nxt = arb_index;
          last_nxt  = arb_index;
        end
      end
      ST_LOCK: begin
        if (accept_last || timeout_hit) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant_id   <= '0;
      last_grant <= IW'(N_PORTS - 1);
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      last_grant <= last_nxt;
    end
  end

  // Load and drain may coincide, which keeps one beat per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= beat_data;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] stall_cnt;
  logic          stall;
  logic          timeout_q;

  assign stall       = (state == ST_LOCK) && !s_axis_tvalid[grant_id];
  // Trips on the stall cycle that brings the count up to TIMEOUT_CYCLES.
  assign timeout_hit = stall && (stall_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign timeout     = timeout_q;

  // Held at zero in IDLE so every new grant starts from a clean count;
  // last_grant is left alone so the stalled port loses the next round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      if (state == ST_IDLE || accept) stall_cnt <= '0;
      else if (stall)                 stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] tdata = '0;
  logic [3:0]  tvalid = '0;
  logic [3:0]  tlast = '0;
  logic [3:0]  s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [1:0]  grant;
  logic        busy;
  logic        timeout;

  int n_checks = 0;
  int n_err    = 0;

  uart_tx_arb #(
    .N_PORTS        (4),
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tlast  (tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .grant_id      (grant),
    .busy          (busy),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "bench time limit");
  end

  typedef struct {
    logic [3:0]  tvalid;
    logic [3:0]  tlast;
    logic [31:0] tdata;
    logic        mready;
    logic [3:0]  x_tready;
    logic        x_mvalid;
    logic [7:0]  x_mdata;
    logic [1:0]  x_grant;
    logic        x_busy;
  } vec_t;

  vec_t vecs[13];

  // per-port packet sources
  logic [7:0] sdata [4][16];
  logic       slast [4][16];
  int         slen [4];
  int         sptr [4];
  bit         sen [4];
  logic [3:0] fire_prev;
  logic [7:0] out_q[$];

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l,
                              input logic [31:0] d, input logic mr,
                              input logic [3:0] xr, input logic xv,
                              input logic [7:0] xd, input logic [1:0] xg,
                              input logic xb);
    vec_t r;
    r.tvalid = v; r.tlast = l; r.tdata = d; r.mready = mr;
    r.x_tready = xr; r.x_mvalid = xv; r.x_mdata = xd; r.x_grant = xg; r.x_busy = xb;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic load_src(input int p, input logic [7:0] base, input int n, input int pktlen);
    for (int k = 0; k < n; k++) begin
      sdata[p][k] = base + 8'(k);
      slast[p][k] = ((k + 1) % pktlen == 0);
    end
    slen[p] = n;
    sptr[p] = 0;
    sen[p]  = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int p = 0; p < 4; p++) begin
      sen[p] = 1'b0; sptr[p] = 0; slen[p] = 0;
    end
    fire_prev = '0;
    out_q.delete();
    tvalid = '0; tlast = '0; tdata = '0; m_tready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: advance sources past last cycle's handshakes, drive,
  // then sample away from the rising edge.
  task automatic cycle(input logic mr);
    @(negedge clk);
    for (int p = 0; p < 4; p++) if (fire_prev[p]) sptr[p]++;
    for (int p = 0; p < 4; p++) begin
      if (sen[p] && sptr[p] < slen[p]) begin
        tvalid[p]       = 1'b1;
        tdata[p*8 +: 8] = sdata[p][sptr[p]];
        tlast[p]        = slast[p][sptr[p]];
      end else begin
        tvalid[p]       = 1'b0;
        tdata[p*8 +: 8] = 8'h00;
        tlast[p]        = 1'b0;
      end
    end
    m_tready = mr;
    #1;
    fire_prev = s_tready & tvalid;
    if (m_tvalid && m_tready) out_q.push_back(m_tdata);
  endtask

  initial begin
    int n;
    int fire_at[3];
    int nf;
    logic [7:0] exp_b;

    // ---------------- table-driven: single port, then rotation ----------
    vecs[0]  = mk(4'b0100, 4'b0000, 32'h0041_0000, 1, 4'b0000, 0, 8'h00, 2'd0, 0);
    vecs[1]  = mk(4'b0100, 4'b0000, 32'h0041_0000, 1, 4'b0100, 0, 8'h00, 2'd2, 1);
    vecs[2]  = mk(4'b0100, 4'b0000, 32'h0042_0000, 1, 4'b0100, 1, 8'h41, 2'd2, 1);
    vecs[3]  = mk(4'b0100, 4'b0100, 32'h0043_0000, 1, 4'b0100, 1, 8'h42, 2'd2, 1);
    vecs[4]  = mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 1, 8'h43, 2'd2, 1);
    vecs[5]  = mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 8'h43, 2'd2, 0);
    vecs[6]  = mk(4'b1001, 4'b1001, 32'h5A00_0011, 0, 4'b0000, 0, 8'h43, 2'd2, 0);
    vecs[7]  = mk(4'b1001, 4'b1001, 32'h5A00_0011, 0, 4'b1000, 0, 8'h43, 2'd3, 1);
    vecs[8]  = mk(4'b1001, 4'b1001, 32'h5A00_0011, 0, 4'b0000, 1, 8'h5A, 2'd3, 1);
    vecs[9]  = mk(4'b0001, 4'b0001, 32'h0000_0011, 0, 4'b0000, 1, 8'h5A, 2'd0, 1);
    vecs[10] = mk(4'b0001, 4'b0001, 32'h0000_0011, 1, 4'b0001, 1, 8'h5A, 2'd0, 1);
    vecs[11] = mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 1, 8'h11, 2'd0, 1);
    vecs[12] = mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 8'h11, 2'd0, 0);

    #1;
    check("reset_outputs", {s_tready, m_tvalid, m_tdata, grant, busy, timeout}, 64'h0);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      tvalid = vecs[i].tvalid; tlast = vecs[i].tlast;
      tdata = vecs[i].tdata; m_tready = vecs[i].mready;
      #1;
      check($sformatf("vec%0d", i),
            {s_tready, m_tvalid, m_tdata, grant, busy, timeout},
            {vecs[i].x_tready, vecs[i].x_mvalid, vecs[i].x_mdata,
             vecs[i].x_grant, vecs[i].x_busy, 1'b0});
    end

    // ---------------- round robin, all ports busy ----------------------
    do_reset();
    for (int p = 0; p < 4; p++) load_src(p, 8'(p * 16), 6, 2);
    n = 0;
    while (out_q.size() < 24 && n < 300) begin cycle(1'b1); n++; end
    check("rr_cycles", n, 37);
    for (int j = 0; j < 24; j++) begin
      exp_b = 8'(((j / 2) % 4) * 16 + ((j / 2) / 4) * 2 + (j % 2));
      if (j < out_q.size()) check($sformatf("rr_byte%0d", j), out_q[j], exp_b);
      else check($sformatf("rr_byte%0d", j), 64'hFFFF, exp_b);
    end

    // ---------------- no interleave under sparse ready -----------------
    do_reset();
    load_src(0, 8'hA0, 4, 4);
    load_src(1, 8'hB0, 2, 2);
    n = 0;
    while (out_q.size() < 6 && n < 200) begin cycle(n % 3 == 0); n++; end
    check("ni_count", out_q.size(), 6);
    for (int j = 0; j < 6 && j < out_q.size(); j++)
      check($sformatf("ni_byte%0d", j), out_q[j], (j < 4) ? 8'hA0 + 8'(j) : 8'hB0 + 8'(j - 4));

    // ---------------- backpressure --------------------------------------
    do_reset();
    load_src(2, 8'hC0, 3, 3);
    cycle(1'b0);
    cycle(1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0);
      check($sformatf("bp_hold%0d", i), {s_tready, m_tvalid, m_tdata}, {4'b0000, 1'b1, 8'hC0});
    end
    nf = 0;
    for (int i = 0; i < 10; i++) begin
      n = out_q.size();
      cycle(1'b1);
      if (out_q.size() > n && nf < 3) begin fire_at[nf] = i; nf++; end
    end
    check("bp_count", out_q.size(), 3);
    if (nf == 3) check("bp_rate", fire_at[2] - fire_at[0], 2);
    for (int j = 0; j < 3 && j < out_q.size(); j++)
      check($sformatf("bp_byte%0d", j), out_q[j], 8'hC0 + 8'(j));

    // ---------------- reset mid-packet ----------------------------------
    do_reset();
    load_src(1, 8'h71, 5, 5);
    cycle(1'b1); cycle(1'b1); cycle(1'b1);
    @(posedge clk);
    #2;
    check("pre_rst_state", {m_tvalid, m_tdata, grant, busy}, {1'b1, 8'h72, 2'd1, 1'b1});
    rst = 1'b1;
    #1;
    check("mid_rst_outputs", {s_tready, m_tvalid, m_tdata, grant, busy, timeout}, 64'h0);
    do_reset();
    load_src(0, 8'h0F, 1, 1);
    load_src(3, 8'h3F, 1, 1);
    cycle(1'b1);
    cycle(1'b1);
    check("post_rst_grant", {grant, s_tready}, {2'd0, 4'b0001});
    n = 0;
    while (out_q.size() < 1 && n < 10) begin cycle(1'b1); n++; end
    check("post_rst_first", (out_q.size() > 0) ? out_q[0] : 8'hFF, 8'h0F);

    // ---------------- stalled grant -------------------------------------
    do_reset();
    load_src(1, 8'hD1, 1, 2);
    load_src(3, 8'hD3, 1, 1);
    for (int c = 0; c < 16; c++) begin
      cycle(1'b1);
`ifdef UART_TX_ARB_TIMEOUT_EN
      check($sformatf("to_pulse_c%0d", c), timeout, (c == 12));
      if (c == 13) check("to_regrant", {grant, s_tready}, {2'd3, 4'b1000});
`else
      check($sformatf("to_off_c%0d", c), timeout, 1'b0);
      if (c == 13) check("to_held", {grant, s_tready, busy}, {2'd1, 4'b0010, 1'b1});
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin, packet-locked arbiter that shares one AXI4-Stream UART transmitter among `N_PORTS` byte-stream requesters (console, debug dump, telemetry). Sits between the requesters and the UART TX input and holds a grant from first beat to `tlast` so that messages never interleave on the wire. A registered output stage isolates the UART's `tready` from the requester-side logic.

## Interface
- `N_PORTS`, 4: number of requesters, 2..8
- `DATA_WIDTH`, 8: beat width; must match the UART TX
- `TIMEOUT_CYCLES`, 65535: stall limit for the watchdog (used only with `UART_TX_ARB_TIMEOUT_EN`), ≥1
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `s_axis_tdata`  in  N_PORTS*DATA_WIDTH  packed requester data; port i is slice [i*DATA_WIDTH +: DATA_WIDTH]
- `s_axis_tvalid`  in  N_PORTS  per-port valid
- `s_axis_tlast`  in  N_PORTS  per-port end of message
- `s_axis_tready`  out  N_PORTS  per-port ready
- `m_axis_tdata`  out  DATA_WIDTH  to UART TX
- `m_axis_tvalid`  out  1  to UART TX
- `m_axis_tready`  in  1  from UART TX
- `grant_id`  out  clog2(N_PORTS)  index of the locked port; meaningful while `busy`
- `busy`  out  1  state is LOCK or output register full
- `timeout`  out  1  one-cycle pulse when the watchdog releases a grant; constant 0 without the macro

## Operation
- States: IDLE and LOCK.
- IDLE: when any `s_axis_tvalid` is high, pick the first valid port searching upward from `(last_grant+1) mod N_PORTS`. Register `grant_id` and `last_grant`, then go to LOCK. No beat is accepted in IDLE.
- LOCK: `s_axis_tready[grant_id] = !m_axis_tvalid || m_axis_tready`. All other readys are 0.
- Accepted beat (granted valid & ready): load the output register with the beat; `m_axis_tvalid` is set.
- Output register: `m_axis_tvalid` clears on `m_axis_tready` when no new beat loads in the same cycle. Simultaneous drain and load is allowed, giving full throughput.
- Accepted beat with `tlast` = 1: return to IDLE next cycle. The output register continues to drain independently.
- Requests that arrive while in LOCK are ignored until IDLE.
- `tlast` is not forwarded; the UART has no framing.
- Reset values: state IDLE, `last_grant` = N_PORTS-1 (so port 0 wins first), `grant_id` 0, `m_axis_tvalid` 0, `m_axis_tdata` 0, all `s_axis_tready` 0, `busy` 0, `timeout` 0, timeout counter 0.
- Reset asserted mid-packet: everything is cleared immediately (asynchronous assert); the partial message is dropped with no recovery. Deassertion is synchronous to `clk`.

## Timing
- Request to grant: valid in cycle 0 → LOCK and `s_axis_tready` high in cycle 1. The first beat is accepted in cycle 1 and `m_axis_tvalid` is high in cycle 2.
- Steady state: one beat per cycle when `m_axis_tready` is held high. In practice it is one beat per UART character time.
- Packet-to-packet: `tlast` accepted in cycle n → IDLE in cycle n+1 → next grant in LOCK in cycle n+2. This gives exactly one bubble cycle.
- `s_axis_tready` is combinational from state registers and `m_axis_tready` only; there is no path from any `s_axis_tvalid`.

## Configuration
- `UART_TX_ARB_TIMEOUT_EN` defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) increments each LOCK cycle in which the granted port's `tvalid` is low, and clears on every accepted beat and on entering LOCK.
  - When the counter reaches `TIMEOUT_CYCLES`, the block goes to IDLE and pulses `timeout` for one cycle.
  - `last_grant` keeps the stalled port's index, so the next arbitration rotates past it.
- Not defined: no counter is built, the grant is held indefinitely until `tlast`, and `timeout` is tied to 0.

## Structure
- Shared package `uart_pkg`:
  - state encoding constants (IDLE = 0, LOCK = 1)
  - the clog2 helper function used for `grant_id` and counter widths
- One sub-module, `uart_rr_arbiter`: a combinational rotating priority encoder.
  - Inputs: request vector and `last_grant`.
  - Outputs: `found` and `index`.
- State, output register and timeout logic live in the top level.

## Test plan
- Single port: port 2 sends 3 bytes 0x41, 0x42, 0x43 (tlast on 0x43) with `m_axis_tready` held high → bytes appear in order, `grant_id` = 2, `m_axis_tvalid` first high 2 cycles after `tvalid`, `busy` falls after the last drain.
- Round-robin: all 4 ports continuously send 2-byte packets tagged with the port number → grant order is 0,1,2,3,0 and no port receives two grants while another waits.
- No interleave: port 0 sends 4 bytes while `m_axis_tready` toggles every 1-in-3 cycles and port 1 is valid throughout → all 4 port-0 bytes are emitted before any port-1 byte, and none are lost or duplicated.
- Backpressure: `m_axis_tready` is held low 20 cycles with the output register full → `s_axis_tready` stays 0 and `m_axis_tdata` stays stable; when ready returns, one beat transfers per cycle.
- Reset mid-packet: `rst` is pulsed after the 2nd of 5 bytes → all outputs take their reset values in the same cycle, and the next arbitration grants port 0.
- Timeout (macro on, TIMEOUT_CYCLES = 10): port 1 sends 1 byte without `tlast` then drops valid, while port 3 is valid → `timeout` pulses on stall cycle 10 and port 3 is granted the following cycle.
